// File: rtl/ifetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Imported by the fetch top, its settle counter and the bus interface.
package ifetch_stage_pkg;

    localparam int PC_MSB   = 11;
    localparam int PC_W     = PC_MSB + 1;
    localparam int INSTR_W  = 16;
    localparam int CNT_W    = 3;
    localparam int ADD_STEP = 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        FLUSH,
        SETTLE
    } fetch_state_e;

endpackage

// File: rtl/ifetch_stage_if.sv
// Memory read port and decode handshake of the fetch stage, bundled together.
// The master side is the fetch stage; the slave side is memory plus decode.
interface ifetch_stage_if
    import ifetch_stage_pkg::*;
#(
    parameter int AW = PC_W,
    parameter int DW = INSTR_W
);

    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          dec_ready;

    modport master (
        output mem_rd, mem_addr,
        input  mem_rdata, mem_ack,
        output instr, instr_pc, instr_valid,
        input  dec_ready
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_rdata, mem_ack,
        input  instr, instr_pc, instr_valid,
        output dec_ready
    );

endinterface

// File: rtl/ifetch_stage_settle_counter.sv
// Down-counter that models the PC stage update latency after an add_value pulse.
// Load wins over decrement; decrement saturates at zero.
module settle_counter
    import ifetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is always written with <=, so every flop samples
    // the pre-edge values and the order of statements cannot create races.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: reads the word at pc_value, holds it for decode,
// and tells the PC stage how far to move (0, +1, or a branch offset).
module ifetch_stage
    import ifetch_stage_pkg::*;
#(
    parameter int N      = PC_MSB,
    parameter int W      = INSTR_W,
    parameter int PC_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N:0]     pc_value,
    output logic [N:0]     add_value,
    input  logic           branch_taken,
    input  logic [N:0]     branch_offset,
    ifetch_stage_if.master bus
);

    fetch_state_e state_q, state_d;

    logic         mem_rd_q, mem_rd_d;
    logic [N:0]   mem_addr_q, mem_addr_d;
    logic [W-1:0] instr_q, instr_d;
    logic [N:0]   instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic [N:0]   add_q, add_d;

    logic         cnt_load;
    logic         cnt_dec;
    logic         cnt_zero;

    settle_counter u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(PC_LAT)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        mem_rd_d      = mem_rd_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        add_d         = '0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;

        // A redirect overrides any same-cycle ack or decode handshake.
        if (branch_taken && (state_q inside {REQ, HOLD, SETTLE})) begin
            add_d         = branch_offset;
            instr_valid_d = 1'b0;
            mem_rd_d      = 1'b0;
            cnt_load      = 1'b1;
            state_d       = (state_q == REQ && !bus.mem_ack) ? FLUSH : SETTLE;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc_value;
                    state_d    = REQ;
                end

                REQ: begin
                    if (bus.mem_ack) begin
                        instr_d       = bus.mem_rdata;
                        instr_pc_d    = mem_addr_q;
                        instr_valid_d = 1'b1;
                        mem_rd_d      = 1'b0;
                        add_d         = (N+1)'(ADD_STEP);
                        state_d       = HOLD;
                    end
                end

                HOLD: begin
                    if (instr_valid_q && bus.dec_ready) begin
                        instr_valid_d = 1'b0;
                        cnt_load      = 1'b1;
                        state_d       = SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt_zero) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = pc_value;
                        state_d    = REQ;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end

                FLUSH: begin
                    // The abandoned read must still complete before a new one
                    // may be issued; its data is dropped.
                    cnt_dec = 1'b1;
                    if (bus.mem_ack) begin
                        if (cnt_zero) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = pc_value;
                            state_d    = REQ;
                        end else begin
                            state_d = SETTLE;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            add_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            add_q         <= add_d;
        end
    end

    assign add_value       = add_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: drives inputs and samples outputs on the
// falling clock edge, with expected values worked out by hand per scenario.
module tb_ifetch_stage;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [11:0] pc_value;
    logic [11:0] add_value;
    logic        branch_taken;
    logic [11:0] branch_offset;

    int errors;
    int checks;

    ifetch_stage_if #(.AW(12), .DW(16)) bus ();

    ifetch_stage #(.N(11), .W(16), .PC_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_value      (pc_value),
        .add_value     (add_value),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .bus           (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({add_value, bus.mem_rd, bus.mem_addr, bus.instr, bus.instr_pc, bus.instr_valid} !== 54'd0) begin
            errors++;
            $display("FAIL reset_outputs: got add=%h rd=%b addr=%h instr=%h ipc=%h v=%b want all 0",
                     add_value, bus.mem_rd, bus.mem_addr, bus.instr, bus.instr_pc, bus.instr_valid);
        end
    endtask

    task automatic test_fetch();
        pc_value      = 12'h000;
        bus.dec_ready = 1'b1;
        rst           = 1'b0;
        cyc();
        checks++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h000}) begin
            errors++; $display("FAIL fetch_req: got rd=%b addr=%h want rd=1 addr=000", bus.mem_rd, bus.mem_addr);
        end
        bus.mem_rdata = 16'hA5A5;
        bus.mem_ack   = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid} !== {16'hA5A5, 12'h000, 1'b1}) begin
            errors++; $display("FAIL fetch_data: got instr=%h ipc=%h v=%b want A5A5 000 1", bus.instr, bus.instr_pc, bus.instr_valid);
        end
        checks++;
        if ({add_value, bus.mem_rd} !== {12'h001, 1'b0}) begin
            errors++; $display("FAIL fetch_add: got add=%h rd=%b want add=001 rd=0", add_value, bus.mem_rd);
        end
        pc_value = 12'h001;
        cyc();
        checks++;
        if ({add_value, bus.instr_valid} !== {12'h000, 1'b0}) begin
            errors++; $display("FAIL fetch_handshake: got add=%h v=%b want add=000 v=0", add_value, bus.instr_valid);
        end
        for (int i = 0; i < LAT; i++) begin
            cyc();
            checks++;
            if (bus.mem_rd !== 1'b0) begin
                errors++; $display("FAIL fetch_settle: cycle %0d got rd=%b want 0", i, bus.mem_rd);
            end
        end
        cyc();
        checks++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h001}) begin
            errors++; $display("FAIL fetch_next: got rd=%b addr=%h want rd=1 addr=001", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_backpressure();
        bus.dec_ready = 1'b0;
        bus.mem_rdata = 16'h1234;
        bus.mem_ack   = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid, add_value} !== {16'h1234, 12'h001, 1'b1, 12'h001}) begin
            errors++; $display("FAIL bp_data: got instr=%h ipc=%h v=%b add=%h want 1234 001 1 001",
                               bus.instr, bus.instr_pc, bus.instr_valid, add_value);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_rd, add_value} !== {1'b1, 16'h1234, 12'h001, 1'b0, 12'h000}) begin
                errors++; $display("FAIL bp_hold: cycle %0d got v=%b instr=%h ipc=%h rd=%b add=%h want 1 1234 001 0 000",
                                   i, bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_rd, add_value);
            end
        end
        pc_value      = 12'h002;
        bus.dec_ready = 1'b1;
        cyc();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got v=%b want 0", bus.instr_valid);
        end
        for (int i = 0; i < LAT; i++) begin
            cyc();
            checks++;
            if (bus.mem_rd !== 1'b0) begin
                errors++; $display("FAIL bp_settle: cycle %0d got rd=%b want 0", i, bus.mem_rd);
            end
        end
        cyc();
        checks++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h002}) begin
            errors++; $display("FAIL bp_next: got rd=%b addr=%h want rd=1 addr=002", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({bus.mem_rd, bus.mem_addr, add_value, bus.instr_valid} !== {1'b1, 12'h002, 12'h000, 1'b0}) begin
                errors++; $display("FAIL lat_wait: cycle %0d got rd=%b addr=%h add=%h v=%b want 1 002 000 0",
                                   i, bus.mem_rd, bus.mem_addr, add_value, bus.instr_valid);
            end
        end
        bus.mem_rdata = 16'hBEEF;
        bus.mem_ack   = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid, add_value} !== {16'hBEEF, 12'h002, 1'b1, 12'h001}) begin
            errors++; $display("FAIL lat_data: got instr=%h ipc=%h v=%b add=%h want BEEF 002 1 001",
                               bus.instr, bus.instr_pc, bus.instr_valid, add_value);
        end
        pc_value = 12'h100;
        cyc();
        checks++;
        if ({add_value, bus.instr_valid} !== {12'h000, 1'b0}) begin
            errors++; $display("FAIL lat_single_pulse: got add=%h v=%b want 000 0", add_value, bus.instr_valid);
        end
        for (int i = 0; i < LAT; i++) cyc();
        cyc();
        checks++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h100}) begin
            errors++; $display("FAIL lat_next: got rd=%b addr=%h want rd=1 addr=100", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_redirect_req();
        branch_taken  = 1'b1;
        branch_offset = 12'hFFC;
        cyc();
        branch_taken = 1'b0;
        checks++;
        if ({add_value, bus.mem_rd, bus.instr_valid} !== {12'hFFC, 1'b0, 1'b0}) begin
            errors++; $display("FAIL redir_add: got add=%h rd=%b v=%b want FFC 0 0", add_value, bus.mem_rd, bus.instr_valid);
        end
        cyc();
        checks++;
        if (add_value !== 12'h000) begin
            errors++; $display("FAIL redir_pulse: got add=%h want 000", add_value);
        end
        bus.mem_rdata = 16'hDEAD;
        bus.mem_ack   = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.mem_rd, add_value} !== {1'b0, 1'b0, 12'h000}) begin
            errors++; $display("FAIL redir_drop: got v=%b rd=%b add=%h want 0 0 000", bus.instr_valid, bus.mem_rd, add_value);
        end
        pc_value = 12'h0FC;
        cyc();
        checks++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h0FC}) begin
            errors++; $display("FAIL redir_next: got rd=%b addr=%h want rd=1 addr=0FC", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_flush_saturate();
        branch_taken  = 1'b1;
        branch_offset = 12'h004;
        cyc();
        branch_taken = 1'b0;
        checks++;
        if (add_value !== 12'h004) begin
            errors++; $display("FAIL flush_add: got add=%h want 004", add_value);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({bus.mem_rd, add_value, bus.instr_valid} !== {1'b0, 12'h000, 1'b0}) begin
                errors++; $display("FAIL flush_wait: cycle %0d got rd=%b add=%h v=%b want 0 000 0",
                                   i, bus.mem_rd, add_value, bus.instr_valid);
            end
        end
        pc_value      = 12'h100;
        bus.mem_rdata = 16'h1357;
        bus.mem_ack   = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.mem_rd, bus.mem_addr, bus.instr_valid} !== {1'b1, 12'h100, 1'b0}) begin
            errors++; $display("FAIL flush_direct_req: got rd=%b addr=%h v=%b want 1 100 0", bus.mem_rd, bus.mem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_ack_branch();
        bus.mem_rdata = 16'hCAFE;
        bus.mem_ack   = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 12'h010;
        cyc();
        bus.mem_ack  = 1'b0;
        branch_taken = 1'b0;
        checks++;
        if ({add_value, bus.instr_valid, bus.mem_rd} !== {12'h010, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ackbr_add: got add=%h v=%b rd=%b want 010 0 0", add_value, bus.instr_valid, bus.mem_rd);
        end
        pc_value = 12'h110;
        for (int i = 0; i < LAT; i++) begin
            cyc();
            checks++;
            if ({bus.mem_rd, add_value, bus.instr_valid} !== {1'b0, 12'h000, 1'b0}) begin
                errors++; $display("FAIL ackbr_settle: cycle %0d got rd=%b add=%h v=%b want 0 000 0",
                                   i, bus.mem_rd, add_value, bus.instr_valid);
            end
        end
        cyc();
        checks++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h110}) begin
            errors++; $display("FAIL ackbr_next: got rd=%b addr=%h want rd=1 addr=110", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_branch_handshake();
        bus.dec_ready = 1'b0;
        bus.mem_rdata = 16'h0F0F;
        bus.mem_ack   = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid, add_value} !== {16'h0F0F, 12'h110, 1'b1, 12'h001}) begin
            errors++; $display("FAIL brhs_data: got instr=%h ipc=%h v=%b add=%h want 0F0F 110 1 001",
                               bus.instr, bus.instr_pc, bus.instr_valid, add_value);
        end
        cyc();
        bus.dec_ready = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 12'h020;
        cyc();
        branch_taken = 1'b0;
        checks++;
        if ({add_value, bus.instr_valid} !== {12'h020, 1'b0}) begin
            errors++; $display("FAIL brhs_add: got add=%h v=%b want 020 0", add_value, bus.instr_valid);
        end
        pc_value = 12'h130;
        for (int i = 0; i < LAT; i++) begin
            cyc();
            checks++;
            if ({bus.mem_rd, add_value} !== {1'b0, 12'h000}) begin
                errors++; $display("FAIL brhs_settle: cycle %0d got rd=%b add=%h want 0 000", i, bus.mem_rd, add_value);
            end
        end
        cyc();
        checks++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h130}) begin
            errors++; $display("FAIL brhs_next: got rd=%b addr=%h want rd=1 addr=130", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        cyc();
        checks++;
        if ({add_value, bus.mem_rd, bus.mem_addr, bus.instr, bus.instr_pc, bus.instr_valid} !== 54'd0) begin
            errors++; $display("FAIL midrst_outputs: got add=%h rd=%b addr=%h instr=%h ipc=%h v=%b want all 0",
                               add_value, bus.mem_rd, bus.mem_addr, bus.instr, bus.instr_pc, bus.instr_valid);
        end
        rst           = 1'b0;
        pc_value      = 12'h200;
        bus.mem_rdata = 16'h1111;
        bus.mem_ack   = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 12'h040;
        cyc();
        bus.mem_ack  = 1'b0;
        branch_taken = 1'b0;
        checks++;
        if ({bus.mem_rd, bus.mem_addr, bus.instr_valid, add_value} !== {1'b1, 12'h200, 1'b0, 12'h000}) begin
            errors++; $display("FAIL midrst_restart: got rd=%b addr=%h v=%b add=%h want 1 200 0 000",
                               bus.mem_rd, bus.mem_addr, bus.instr_valid, add_value);
        end
        bus.mem_rdata = 16'h2222;
        bus.mem_ack   = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid, add_value} !== {16'h2222, 12'h200, 1'b1, 12'h001}) begin
            errors++; $display("FAIL midrst_fetch: got instr=%h ipc=%h v=%b add=%h want 2222 200 1 001",
                               bus.instr, bus.instr_pc, bus.instr_valid, add_value);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        pc_value      = '0;
        branch_taken  = 1'b0;
        branch_offset = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        bus.dec_ready = 1'b0;

        test_reset();
        test_fetch();
        test_backpressure();
        test_latency();
        test_redirect_req();
        test_flush_saturate();
        test_ack_branch();
        test_branch_handshake();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
